// File: rtl/spi_slave.sv
// ============================================================================
//  Module   : spi_slave
//  Brief    : SPI slave front end for a single-port RAM; optional frame_err
//             output enabled by defining SPI_FRAME_ERR_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module spi_slave #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   SS_n,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic [ADDR_SIZE+1:0]   rx_data,
    output logic                   rx_valid,
    input  logic [ADDR_SIZE-1:0]   tx_data,
    input  logic                   tx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic                   frame_err
`endif
);

    localparam int WORD_W = ADDR_SIZE + 2;
    localparam int BCNT_W = $clog2(WORD_W + 1);
    localparam int MCNT_W = $clog2(ADDR_SIZE + 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(WORD_W - 1);
    localparam logic [BCNT_W-1:0] BIT_DONE  = BCNT_W'(WORD_W);
    localparam logic [MCNT_W-1:0] MISO_DONE = MCNT_W'(ADDR_SIZE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t                 state_q;
    logic [WORD_W-1:0]      shift_q;
    logic [BCNT_W-1:0]      bit_cnt_q;
    logic [ADDR_SIZE-1:0]   tx_shift_q;
    logic [MCNT_W-1:0]      miso_cnt_q;
    logic                   rd_addr_seen_q;
    logic [WORD_W-1:0]      rx_data_q;
    logic                   rx_valid_q;
    logic                   miso_q;
    logic [WORD_W-1:0]      shift_d;
`ifdef SPI_FRAME_ERR_EN
    logic                   frame_err_q;
`endif

    assign shift_d  = {shift_q[WORD_W-2:0], MOSI};
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign MISO     = miso_q;
`ifdef SPI_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            tx_shift_q     <= '0;
            miso_cnt_q     <= '0;
            rd_addr_seen_q <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err_q    <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!SS_n) state_q <= CHK_CMD;
                end
                CHK_CMD: begin
                    if (SS_n)                state_q <= IDLE;
                    else if (!MOSI)          state_q <= WRITE;
                    else if (rd_addr_seen_q) state_q <= READ_DATA;
                    else                     state_q <= READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (SS_n) begin
                        // Deselect beats everything, including a final bit on this edge.
                        state_q    <= IDLE;
                        shift_q    <= '0;
                        bit_cnt_q  <= '0;
                        tx_shift_q <= '0;
                        miso_cnt_q <= '0;
                        miso_q     <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
                        frame_err_q <= (bit_cnt_q != BIT_DONE) ||
                                       ((state_q == READ_DATA) && (miso_cnt_q != MISO_DONE));
`endif
                    end else if (bit_cnt_q != BIT_DONE) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            rx_data_q  <= shift_d;
                            rx_valid_q <= 1'b1;
                            if (state_q == READ_ADD)  rd_addr_seen_q <= 1'b1;
                            if (state_q == READ_DATA) rd_addr_seen_q <= 1'b0;
                        end
                    end else if (state_q == READ_DATA) begin
                        // miso_cnt_q == 0 means still waiting for the RAM.
                        if (miso_cnt_q == '0) begin
                            if (tx_valid) begin
                                miso_q     <= tx_data[ADDR_SIZE-1];
                                tx_shift_q <= tx_data << 1;
                                miso_cnt_q <= MCNT_W'(1);
                            end
                        end else if (miso_cnt_q != MISO_DONE) begin
                            miso_q     <= tx_shift_q[ADDR_SIZE-1];
                            tx_shift_q <= tx_shift_q << 1;
                            miso_cnt_q <= miso_cnt_q + 1'b1;
                        end else begin
                            miso_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: directed vector table, reset-mid-read sequence and
// randomized frames checked against a frame-level reference model.
`default_nettype none

module tb_spi_slave;

    localparam int AS = 8;
    localparam int W  = AS + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          SS_n = 1'b1;
    logic          MOSI = 1'b0;
    logic          tx_valid = 1'b0;
    logic [AS-1:0] tx_data = '0;
    logic          MISO;
    logic          rx_valid;
    logic [W-1:0]  rx_data;
`ifdef SPI_FRAME_ERR_EN
    logic          frame_err;
`endif

    spi_slave #(.ADDR_SIZE(AS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_rx   = '0;
    bit           m_seen = 1'b0;

    typedef struct {
        bit            sel;
        logic [W-1:0]  word;
        int            abort_bit;   // W = no abort during the word
        int            tx_delay;
        logic [AS-1:0] txd;
        int            miso_stop;   // AS = all bits shifted, 0 = abort while waiting
        int            hold;
        logic [W-1:0]  exp_rx;
        bit            exp_seen;
    } vec_t;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ferr(string name, bit e);
`ifdef SPI_FRAME_ERR_EN
        chk(name, frame_err, e);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic end_frame(bit exp_err);
        SS_n     = 1'b1;
        MOSI     = 1'($urandom);
        tx_valid = 1'($urandom);
        step();
        chk("abort_rx_valid", rx_valid, 1'b0);
        chk("abort_miso", MISO, 1'b0);
        chk("abort_rx_data", rx_data, m_rx);
        chk("abort_seen", dut.rd_addr_seen_q, m_seen);
        chk_ferr("frame_err_pulse", exp_err);
        tx_valid = 1'b0;
        step();
        chk_ferr("frame_err_clear", 1'b0);
        chk("idle_rx_valid", rx_valid, 1'b0);
    endtask

    task automatic do_frame(bit sel, logic [W-1:0] word, int abort_bit, int tx_delay,
                            logic [AS-1:0] txd, int miso_stop, int hold);
        int path;
        path = (sel == 1'b0) ? 0 : (m_seen ? 2 : 1);
        SS_n = 1'b0;
        MOSI = 1'($urandom);
        step();
        chk("select_rx_valid", rx_valid, 1'b0);
        MOSI = sel;
        step();
        for (int i = 0; i < W; i++) begin
            if (i == abort_bit) begin
                end_frame(1'b1);
                return;
            end
            MOSI     = word[W-1-i];
            tx_valid = 1'($urandom);
            tx_data  = AS'($urandom);
            step();
            if (i == W-1) begin
                m_rx = word;
                if (path == 1) m_seen = 1'b1;
                if (path == 2) m_seen = 1'b0;
            end
            chk("word_rx_valid", rx_valid, (i == W-1));
            chk("word_rx_data", rx_data, m_rx);
            chk("word_miso", MISO, 1'b0);
        end
        chk("word_seen", dut.rd_addr_seen_q, m_seen);
        if (path == 2) begin
            tx_valid = 1'b0;
            repeat (tx_delay) begin
                step();
                chk("wait_miso", MISO, 1'b0);
                chk("wait_rx_valid", rx_valid, 1'b0);
            end
            if (miso_stop == 0) begin
                end_frame(1'b1);
                return;
            end
            tx_valid = 1'b1;
            tx_data  = txd;
            step();
            chk("miso_bit", MISO, txd[AS-1]);
            for (int b = 1; b < AS; b++) begin
                if (b == miso_stop) begin
                    end_frame(1'b1);
                    return;
                end
                tx_valid = 1'($urandom);
                tx_data  = AS'($urandom);
                step();
                chk("miso_bit", MISO, txd[AS-1-b]);
            end
        end
        repeat (hold) begin
            tx_valid = 1'($urandom);
            tx_data  = AS'($urandom);
            MOSI     = 1'($urandom);
            step();
            chk("hold_miso", MISO, 1'b0);
            chk("hold_rx_valid", rx_valid, 1'b0);
        end
        end_frame(1'b0);
    endtask

    vec_t vecs[11];

    initial begin
        logic [AS-1:0] rd_byte;
        logic [W-1:0]  rd_cmd;

        vecs[0]  = '{0, 10'h005, W, 0, 8'h00, AS, 2, 10'h005, 0};
        vecs[1]  = '{0, 10'h1AA, W, 0, 8'h00, AS, 5, 10'h1AA, 0};
        vecs[2]  = '{1, 10'h205, W, 0, 8'h00, AS, 2, 10'h205, 1};
        vecs[3]  = '{1, 10'h3A5, W, 3, 8'hC3, AS, 3, 10'h3A5, 0};
        vecs[4]  = '{0, 10'h155, 6, 0, 8'h00, AS, 0, 10'h3A5, 0};
        vecs[5]  = '{1, 10'h2FF, 9, 0, 8'h00, AS, 0, 10'h3A5, 0};
        vecs[6]  = '{1, 10'h201, W, 0, 8'h00, AS, 1, 10'h201, 1};
        vecs[7]  = '{1, 10'h3FF, W, 0, 8'h5A, 4,  0, 10'h3FF, 0};
        vecs[8]  = '{1, 10'h2AB, 0, 0, 8'h00, AS, 0, 10'h3FF, 0};
        vecs[9]  = '{1, 10'h2AB, W, 0, 8'h00, AS, 0, 10'h2AB, 1};
        vecs[10] = '{1, 10'h300, W, 2, 8'h00, 0,  0, 10'h300, 0};

        rst_n = 1'b0;
        step();
        step();
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_rx_data", rx_data, '0);
        chk("reset_miso", MISO, 1'b0);
        chk("reset_seen", dut.rd_addr_seen_q, 1'b0);
        chk_ferr("reset_frame_err", 1'b0);
        rst_n = 1'b1;
        step();

        foreach (vecs[k]) begin
            do_frame(vecs[k].sel, vecs[k].word, vecs[k].abort_bit, vecs[k].tx_delay,
                     vecs[k].txd, vecs[k].miso_stop, vecs[k].hold);
            chk("vec_rx_data", rx_data, vecs[k].exp_rx);
            chk("vec_seen", dut.rd_addr_seen_q, vecs[k].exp_seen);
        end

        // Reset in the middle of a MISO burst, then confirm the next read restarts at READ_ADD.
        do_frame(1'b1, 10'h2C7, W, 0, 8'h00, AS, 0);
        chk("pre_reset_seen", dut.rd_addr_seen_q, 1'b1);
        rd_byte = 8'hA5;
        rd_cmd  = 10'h3C0;
        SS_n = 1'b0;
        step();
        MOSI = 1'b1;
        step();
        for (int i = 0; i < W; i++) begin
            MOSI = rd_cmd[W-1-i];
            step();
        end
        chk("rst_seq_rx_data", rx_data, rd_cmd);
        tx_valid = 1'b1;
        tx_data  = rd_byte;
        step();
        tx_valid = 1'b0;
        for (int b = 1; b <= 4; b++) step();
        chk("rst_seq_miso_bit3", MISO, rd_byte[3]);
        rst_n    = 1'b0;
        tx_valid = 1'b1;
        step();
        chk("rst_mid_miso", MISO, 1'b0);
        chk("rst_mid_seen", dut.rd_addr_seen_q, 1'b0);
        chk("rst_mid_rx_valid", rx_valid, 1'b0);
        chk("rst_mid_rx_data", rx_data, '0);
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        SS_n     = 1'b1;
        step();
        m_rx   = '0;
        m_seen = 1'b0;
        do_frame(1'b1, 10'h2C4, W, 0, 8'h00, AS, 3);
        chk("post_rst_read_add", dut.rd_addr_seen_q, 1'b1);

        for (int n = 0; n < 40; n++) begin
            do_frame(1'($urandom),
                     W'($urandom),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W-1)) : W,
                     int'($urandom_range(0, 3)),
                     AS'($urandom),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, AS-1)) : AS,
                     int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL expose parameter ADDR_SIZE, default 8, giving the payload width. The RAM word is ADDR_SIZE+2 bits and the read data is ADDR_SIZE bits.
REQ-002 Port clk, input, 1 bit: the single system clock. It also serves as the SPI bit clock, and all logic SHALL run on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port SS_n, input, 1 bit: SPI slave select, active low.
REQ-005 Port MOSI, input, 1 bit: serial data from the master, MSB first.
REQ-006 Port MISO, output, 1 bit: serial read data to the master, MSB first.
REQ-007 Port rx_data, output, ADDR_SIZE+2 bits: command word to the RAM. Bits [ADDR_SIZE+1:ADDR_SIZE] are the opcode and the low bits are the payload.
REQ-008 Port rx_valid, output, 1 bit: one-cycle strobe marking rx_data as valid.
REQ-009 Port tx_data, input, ADDR_SIZE bits: read data returned by the RAM.
REQ-010 Port tx_valid, input, 1 bit: marks tx_data as valid.

Function
REQ-011 The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA, encoded in a registered state variable.
REQ-012 In IDLE, SS_n=0 sampled on a clock edge SHALL move the FSM to CHK_CMD; otherwise it stays in IDLE.
REQ-013 In CHK_CMD, the FSM SHALL sample MOSI once and branch:
- MOSI=0 -> WRITE.
- MOSI=1 with rd_addr_seen=0 -> READ_ADD.
- MOSI=1 with rd_addr_seen=1 -> READ_DATA.
This select bit SHALL NOT be stored in rx_data.
REQ-014 In WRITE, READ_ADD and READ_DATA, the block SHALL shift MOSI into an (ADDR_SIZE+2)-bit register MSB first, one bit per clock, counted 0..ADDR_SIZE+1.
REQ-015 The cycle after the last bit is sampled, rx_data SHALL load the full word and rx_valid SHALL be 1 for exactly one cycle.
REQ-016 rx_data SHALL hold its value until the next completed word.
REQ-017 A completed READ_ADD word SHALL set rd_addr_seen=1. A completed READ_DATA word SHALL clear rd_addr_seen=0.
REQ-018 After its word completes, READ_DATA SHALL wait, with no timeout, while SS_n=0 for tx_valid=1.
REQ-019 On the first tx_valid=1 cycle in that wait, the block SHALL capture tx_data. It SHALL then drive MISO with bit ADDR_SIZE-1 on the next cycle, followed by one bit per clock down to bit 0, for ADDR_SIZE cycles in total.
REQ-020 tx_valid SHALL be ignored in every state and phase except the READ_DATA wait.
REQ-021 MISO SHALL be 0 whenever no read-data bit is being shifted out.
REQ-022 After its word (WRITE, READ_ADD) or its MISO bits (READ_DATA) finish, the FSM SHALL remain in its state, inert, until SS_n=1.
REQ-023 SS_n=1 sampled in any non-IDLE state SHALL move the FSM to IDLE on that edge and clear the bit counters.
REQ-024 A partial word aborted by SS_n=1 SHALL NOT assert rx_valid, SHALL NOT change rx_data and SHALL NOT change rd_addr_seen.
REQ-025 If SS_n=1 and the final bit sample fall on the same edge, SS_n SHALL win: the word is discarded.
REQ-026 Bit counters SHALL NOT wrap. Once they reach their terminal count they SHALL saturate until SS_n=1.

Reset
REQ-027 On rst_n=0 at a clock edge, the block SHALL set:
- state=IDLE
- rx_data=0, rx_valid=0, MISO=0
- rd_addr_seen=0
- counters and shift registers to 0
- frame_err=0, when present.
REQ-028 Reset mid-frame SHALL abandon the frame with no rx_valid pulse. Reset SHALL take priority over SS_n and tx_valid.

Configuration
REQ-029 With macro SPI_FRAME_ERR_EN defined, the block SHALL add output port frame_err, 1 bit.
REQ-030 frame_err SHALL pulse 1 for one cycle, the cycle after an SS_n=1 abort, when SS_n=1 arrives:
- before the word completes in WRITE, READ_ADD or READ_DATA, or
- in READ_DATA before all ADDR_SIZE MISO bits have been driven.
REQ-031 With SPI_FRAME_ERR_EN undefined, the frame_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Write address: SS_n=0, MOSI 0 then 00_0000_0101 -> rx_valid one cycle with rx_data=10'h005, rd_addr_seen unchanged.
REQ-033 Write data: frame 0 then 01_1010_1010 -> rx_data=10'h1AA, one rx_valid pulse. Holding SS_n=0 a further 5 cycles -> no extra pulse.
REQ-034 Read sequence:
- Frame 1 then 10_0000_0101 -> rx_data=10'h205, rd_addr_seen=1.
- Next frame 1 then 11_xxxx_xxxx -> rx_data[9:8]=2'b11.
- RAM returns tx_valid with tx_data=8'hC3 -> MISO shows 1,1,0,0,0,0,1,1 on 8 consecutive cycles, then 0. rd_addr_seen=0.
REQ-035 Abort: SS_n=1 after 6 of 10 write bits -> no rx_valid, rx_data unchanged, FSM back to IDLE next edge. frame_err=1 for one cycle when the macro is defined.
REQ-036 Reset mid-read: rst_n=0 during MISO bit 3 -> MISO=0, state=IDLE, rd_addr_seen=0 next edge. A following read frame takes the READ_ADD path.
